// File: rtl/palindrome_seq_ctrl.sv
// Sequential palindrome checker: latches a word on start, then compares one mirrored bit pair per cycle.
// Optional PAL_EARLY_EXIT_EN ends the check on the first mismatching pair instead of scanning all pairs.
module palindrome_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(WIDTH/2) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] word,
  output logic             busy,
  output logic             done,
  output logic             out
);

  if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
    $error("palindrome_seq_ctrl: WIDTH must be even and >= 2");
  end

  typedef enum logic {IDLE, CHECK} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH/2 - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] wreg;
  logic [WIDTH-1:0] wrev;
  logic [IDX_W-1:0] idx;
  logic             mismatch;
  logic             pair_mm;
  logic             last_pair;
  logic             finish_chk;

  // Bit-reversed copy lets both sides of the pair be picked with the same index.
  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign wrev[i] = wreg[WIDTH-1-i];
  end

  assign pair_mm   = wreg[idx] ^ wrev[idx];
  assign last_pair = (idx == LAST_IDX);

`ifdef PAL_EARLY_EXIT_EN
  assign finish_chk = last_pair | pair_mm;
`else
  assign finish_chk = last_pair;
`endif

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (finish_chk) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wreg     <= '0;
      idx      <= '0;
      mismatch <= 1'b0;
      done     <= 1'b0;
      out      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            wreg     <= word;
            idx      <= '0;
            mismatch <= 1'b0;
          end
        end
        CHECK: begin
          mismatch <= mismatch | pair_mm;
          if (finish_chk) begin
            // Verdict folds in the pair compared on this same edge.
            done <= 1'b1;
            out  <= ~(mismatch | pair_mm);
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/palindrome_seq_ctrl.md
Name: palindrome_seq_ctrl

Overview:
- Sequential palindrome checker controller.
- Latches a WIDTH-bit word on a start handshake, then steps one mirrored bit pair per cycle through a single shared comparator.
- Reports the verdict with a one-cycle done pulse and a held result.
- Replaces the fully unrolled combinational checker where area matters and a multi-cycle latency is acceptable.

Parameters:
- WIDTH, 32, word width in bits; must be even and >= 2.
- IDX_W, $clog2(WIDTH/2)+1, pair-index counter width (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to check word; sampled only in IDLE.
- word  input  WIDTH  word to check; sampled only on the accepting edge.
- busy  output  1  high while a check is in progress (CHECK state).
- done  output  1  one-cycle pulse, registered; verdict valid in this cycle.
- out  output  1  registered result: 1 = palindrome, 0 = not. Held until the next done.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, busy=0, done=0, out=0, idx=0, mismatch flag=0.
  - Takes priority over every other event, including mid-check; an aborted check produces no done pulse.
- FSM states: IDLE, CHECK.
- IDLE:
  - busy=0.
  - If start=1: latch word into internal reg wreg, set idx=0, clear mismatch, go to CHECK.
  - If start=0: stay in IDLE.
- CHECK:
  - busy=1.
  - Each cycle compares wreg[idx] with wreg[WIDTH-1-idx].
  - Inequality sets mismatch; mismatch is sticky for the current check.
  - idx increments by 1 per cycle. The last pair is idx = WIDTH/2-1.
- Completion edge (edge of the last compare): state goes to IDLE, done=1 for exactly one cycle, out = NOT(mismatch OR current-pair mismatch).
- done deasserts on the following edge unless a new check completes on that edge.
- Latency:
  - Accepting edge E0; compares on E1..E(WIDTH/2).
  - done is high in the cycle after edge E(WIDTH/2), i.e. WIDTH/2 cycles after acceptance (16 for WIDTH=32).
- Throughput: start may be asserted in the done cycle (state is already IDLE) and is accepted. Back-to-back period is WIDTH/2+1 cycles.
- start during CHECK is ignored and not queued. word changes during CHECK have no effect.
- Boundaries:
  - Center pairs need no special case; the WIDTH-even check is a parameter assertion.
  - idx never exceeds WIDTH/2-1; no wrap.
  - All-zero and all-one words are palindromes.
- out is unchanged between done pulses, including while busy.

Optional Feature:
- Macro: PAL_EARLY_EXIT_EN.
- Defined:
  - CHECK terminates on the edge where the first mismatching pair (index j) is compared.
  - done=1 and out=0 in the following cycle; latency is j+1 cycles.
  - Palindromes still take WIDTH/2 cycles.
- Undefined:
  - Always performs all WIDTH/2 compares.
  - Fixed latency WIDTH/2 regardless of data.
  - Verdict is identical in both builds.

Test Plan:
- Reset: hold rst=1 for 2 cycles with start=1 -> busy=0, done=0, out=0 throughout, and for 1 cycle after release if start=0.
- Palindrome: word=32'h8000_0001, start for 1 cycle -> busy=1 for 16 cycles; done=1 exactly 16 cycles after accept, out=1; word=32'h0000_0000 -> same timing, out=1.
- Mismatch early vs late:
  - word=32'h0000_0002 (pair idx 1 differs) -> out=0; done at 16 cycles without PAL_EARLY_EXIT_EN, 2 cycles with it.
  - word=32'h0001_0000 (idx 15) -> out=0; done at 16 cycles in both builds.
- Handshake: accept 32'h8000_0001, then hold start=1 with word=32'h0000_0001 during CHECK -> first result out=1 at cycle 16; the new start is accepted in the done cycle; second done at +17 cycles with out=0 (+2 with the macro).
- Reset mid-check: accept 32'h8000_0001, assert rst on the 5th CHECK cycle -> next cycle busy=0, done=0, out=0; no done pulse ever appears for that request.
- Hold: after a result of out=1, keep start=0 for 20 cycles -> out stays 1, done stays 0.
